// File: rtl/pep_sll_credit_link.sv
// Credit-based SLR crossing: LAT-stage forward pipe into a receive FIFO, credits returned
// through a LAT-stage pipe, and a LAT+1-cycle sideband that carries no flow control.
module pep_sll_credit_link #(
  parameter int DATA_W = 64,
  parameter int SIDE_W = 8,
  parameter int LAT    = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [SIDE_W-1:0] in_side,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [SIDE_W-1:0] out_side,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic [CNT_W-1:0]  fifo_cnt,
  output logic              error
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              accept;
  logic              pop;
  logic              fifo_wr;
  logic              fifo_full;
  logic              fifo_wr_ok;
  logic              credit_full;
  logic              crd_arrive;

  logic [LAT-1:0]    fwd_vld;
  logic [DATA_W-1:0] fwd_data [LAT];
  logic [LAT-1:0]    crd_pipe;
  logic [SIDE_W-1:0] side_pipe [LAT+1];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Pointers wrap at DEPTH explicitly, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_rdy      = (credit_cnt != '0);
  assign accept      = in_vld & in_rdy;
  assign credit_full = (credit_cnt == CNT_W'(DEPTH));
  assign crd_arrive  = crd_pipe[LAT-1];

  assign fifo_wr     = fwd_vld[LAT-1];
  assign fifo_full   = (fifo_cnt == CNT_W'(DEPTH));
  assign fifo_wr_ok  = fifo_wr & ~fifo_full;
  assign out_vld     = (fifo_cnt != '0);
  assign pop         = out_vld & out_rdy;
  assign out_data    = out_vld ? mem[rd_ptr] : '0;
  assign out_side    = side_pipe[LAT];

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      fwd_vld  <= '0;
      crd_pipe <= '0;
    end else begin
      fwd_vld[0]  <= accept;
      crd_pipe[0] <= pop;
      for (int i = 1; i < LAT; i++) begin
        fwd_vld[i]  <= fwd_vld[i-1];
        crd_pipe[i] <= crd_pipe[i-1];
      end
    end
  end

  // NOTE: payload registers and FIFO storage carry no reset; valids and counts qualify them.
  always_ff @(posedge clk) begin
    if (accept) fwd_data[0] <= in_data;
    for (int i = 1; i < LAT; i++) begin
      if (fwd_vld[i-1]) fwd_data[i] <= fwd_data[i-1];
    end
    if (fifo_wr_ok) mem[wr_ptr] <= fwd_data[LAT-1];
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      for (int i = 0; i <= LAT; i++) side_pipe[i] <= '0;
    end else begin
      side_pipe[0] <= in_side;
      for (int i = 1; i <= LAT; i++) side_pipe[i] <= side_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)        rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_wr_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Accept and credit arrival in the same cycle cancel; a surplus credit saturates.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      credit_cnt <= CNT_W'(DEPTH);
    end else begin
      case ({accept, crd_arrive})
        2'b10:   credit_cnt <= credit_cnt - CNT_W'(1);
        2'b01:   if (!credit_full) credit_cnt <= credit_cnt + CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      error <= 1'b0;
    end else if ((fifo_wr & fifo_full) | (crd_arrive & credit_full)) begin
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pep_sll_credit_link.sv
// Self-checking bench for pep_sll_credit_link: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pep_sll_credit_link;

  localparam int DATA_W = 16;
  localparam int SIDE_W = 8;
  localparam int LAT    = 2;
  localparam int DEPTH  = 6;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              s_rst;
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              in_rdy;
  logic [SIDE_W-1:0] in_side;
  logic [DATA_W-1:0] out_data;
  logic              out_vld;
  logic              out_rdy;
  logic [SIDE_W-1:0] out_side;
  logic [CNT_W-1:0]  credit_cnt;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              error;

  pep_sll_credit_link #(
    .DATA_W(DATA_W), .SIDE_W(SIDE_W), .LAT(LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .s_rst(s_rst),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy), .in_side(in_side),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_side(out_side),
    .credit_cnt(credit_cnt), .fifo_cnt(fifo_cnt), .error(error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit cmp_en  = 0;
  bit mon_en  = 0;
  bit spur    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: words and credits in flight are timestamped with the cycle they land.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } fly_t;

  fly_t              m_fly[$];
  logic [DATA_W-1:0] m_fifo[$];
  int                m_crd[$];
  logic [SIDE_W-1:0] m_side_q[$];
  int                m_credits = DEPTH;
  bit                m_err     = 0;

  always @(posedge clk) begin
    int arrive;
    int fsz;
    bit acc;
    bit pp;
    if (s_rst) begin
      m_fly.delete();
      m_fifo.delete();
      m_crd.delete();
      m_side_q.delete();
      for (int i = 0; i <= LAT; i++) m_side_q.push_back('0);
      m_credits = DEPTH;
      m_err     = 0;
    end else begin
      acc    = in_vld && (m_credits != 0);
      fsz    = m_fifo.size();
      pp     = out_rdy && (fsz != 0);
      arrive = spur ? 1 : 0;
      while (m_crd.size() != 0 && m_crd[0] == cyc) begin
        void'(m_crd.pop_front());
        arrive++;
      end
      if (pp) void'(m_fifo.pop_front());
      while (m_fly.size() != 0 && m_fly[0].due == cyc) begin
        if (fsz == DEPTH) m_err = 1;
        else m_fifo.push_back(m_fly[0].data);
        void'(m_fly.pop_front());
      end
      if (arrive > 0 && m_credits == DEPTH) m_err = 1;
      m_credits = m_credits - (acc ? 1 : 0) + arrive;
      if (m_credits > DEPTH) m_credits = DEPTH;
      if (pp)  m_crd.push_back(cyc + LAT);
      if (acc) m_fly.push_back('{data: in_data, due: cyc + LAT});
      m_side_q.push_back(in_side);
      void'(m_side_q.pop_front());
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_in_rdy", in_rdy, (m_credits != 0));
      check("m_credit_cnt", credit_cnt, m_credits);
      check("m_fifo_cnt", fifo_cnt, m_fifo.size());
      check("m_out_vld", out_vld, (m_fifo.size() != 0));
      if (m_fifo.size() != 0) check("m_out_data", out_data, m_fifo[0]);
      check("m_out_side", out_side, m_side_q[0]);
      check("m_error", error, m_err);
      check("m_invariant", int'(credit_cnt) + int'(fifo_cnt) + m_fly.size() + m_crd.size(), DEPTH);
    end
  end

  // Streaming monitor: receiver order and first-arrival cycle.
  logic [DATA_W-1:0] rx_q[$];
  int                first_vld = -1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (out_vld && out_rdy) rx_q.push_back(out_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int g;
    int first_acc;
    int acc_n;
    int last_acc;
    int fc[32];
    bit rdy[10];
    logic [SIDE_W-1:0] side_s[8];

    s_rst = 1; in_vld = 0; in_data = '0; in_side = '0; out_rdy = 0;
    nxt();
    nxt();
    s_rst  = 0;
    cmp_en = 1;

    // Reset values
    @(negedge clk);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_credit_cnt", credit_cnt, 6);
    check("rst_out_vld", out_vld, 0);
    check("rst_fifo_cnt", fifo_cnt, 0);
    check("rst_error", error, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_side", out_side, 0);
    nxt();

    // Streaming 0..99 back-to-back
    out_rdy = 1; mon_en = 1; first_acc = -1; rx_q.delete();
    n = 0; g = 0;
    while (n < 100 && g < 400) begin
      in_vld = 1; in_data = DATA_W'(n);
      @(negedge clk);
      check("stream_in_rdy", in_rdy, 1);
      if (in_rdy) begin
        if (first_acc < 0) first_acc = cyc;
        n++;
      end
      nxt();
      g++;
    end
    in_vld = 0;
    g = 0;
    while (rx_q.size() < 100 && g < 50) begin
      nxt();
      g++;
    end
    check("stream_count", rx_q.size(), 100);
    check("stream_first_latency", first_vld - first_acc, 3);
    for (int i = 0; i < rx_q.size(); i++) check("stream_order", rx_q[i], i);
    mon_en = 0;
    repeat (5) nxt();
    check("stream_error", error, 0);
    check("stream_credits_back", credit_cnt, 6);

    // Backpressure
    out_rdy = 0; acc_n = 0; last_acc = 0;
    for (int i = 0; i < 32; i++) fc[i] = 0;
    for (int k = 0; k < 20; k++) begin
      in_vld = 1; in_data = DATA_W'(16'h1000 + k);
      @(negedge clk);
      if (in_rdy) begin
        acc_n++;
        last_acc = k;
      end
      fc[k] = fifo_cnt;
      nxt();
    end
    check("bp_accepts", acc_n, 6);
    check("bp_in_rdy_low", in_rdy, 0);
    check("bp_fifo_last_plus2", fc[last_acc + 2], 5);
    check("bp_fifo_last_plus3", fc[last_acc + 3], 6);

    // One-cycle pop pulse at j=0 returns exactly one credit at j=3
    acc_n = 0;
    for (int j = 0; j < 10; j++) begin
      out_rdy = (j == 0); in_vld = 1; in_data = DATA_W'(16'h2000 + j);
      @(negedge clk);
      rdy[j] = in_rdy;
      if (in_rdy) acc_n++;
      nxt();
    end
    check("pulse_rdy_p2", rdy[2], 0);
    check("pulse_rdy_p3", rdy[3], 1);
    check("pulse_rdy_p4", rdy[4], 0);
    check("pulse_extra_accepts", acc_n, 1);
    in_vld = 0; out_rdy = 1;
    repeat (12) nxt();
    check("drain_fifo_cnt", fifo_cnt, 0);
    check("drain_credit_cnt", credit_cnt, 6);

    // Accept in the same cycle a credit arrives, with credit_cnt = 1
    out_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      in_vld = 1; in_data = DATA_W'(16'h4000 + k);
      nxt();
    end
    in_vld = 0;
    repeat (4) nxt();
    out_rdy = 1;
    nxt();
    out_rdy = 0;
    nxt();
    in_vld = 1; in_data = DATA_W'(16'h4005);
    @(negedge clk);
    check("sim_credit_before", credit_cnt, 1);
    check("sim_in_rdy_before", in_rdy, 1);
    nxt();
    in_vld = 0;
    @(negedge clk);
    check("sim_credit_after", credit_cnt, 1);
    check("sim_in_rdy_after", in_rdy, 1);
    nxt();
    out_rdy = 1;
    repeat (15) nxt();

    // Randomised traffic, checked every cycle by the model
    for (int k = 0; k < 10000; k++) begin
      in_vld  = ($urandom_range(0, 99) < 70);
      out_rdy = ($urandom_range(0, 99) < 60);
      in_data = DATA_W'($urandom);
      in_side = SIDE_W'($urandom);
      nxt();
    end
    in_vld = 0; in_side = '0; out_rdy = 1;
    repeat (15) nxt();
    check("rand_error", error, 0);

    // Reset mid-stream: FIFO holds 4, two words in the pipe (the credit budget allows no more)
    out_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      in_vld = 1; in_data = DATA_W'(16'h3000 + k);
      nxt();
    end
    in_vld = 0;
    repeat (4) nxt();
    check("mid_fifo_cnt", fifo_cnt, 4);
    in_vld = 1; in_data = DATA_W'(16'h3004);
    nxt();
    in_data = DATA_W'(16'h3005);
    nxt();
    s_rst = 1; in_vld = 1; out_rdy = 1;
    nxt();
    s_rst = 0; in_vld = 0; out_rdy = 1;
    @(negedge clk);
    check("mid_rst_credit_cnt", credit_cnt, 6);
    check("mid_rst_fifo_cnt", fifo_cnt, 0);
    check("mid_rst_error", error, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("mid_rst_no_stale", out_vld, 0);
      nxt();
    end
    check("mid_rst_error_after", error, 0);

    // Sideband: single A5 pulse appears exactly LAT+1 cycles later
    for (int j = 0; j < 8; j++) begin
      in_side = (j == 0) ? 8'hA5 : 8'h00;
      @(negedge clk);
      side_s[j] = out_side;
      nxt();
    end
    for (int j = 0; j < 8; j++) check("side_delay", side_s[j], (j == 3) ? 8'hA5 : 8'h00);

    // Spurious credit while credit_cnt = DEPTH
    spur = 1;
    force dut.crd_arrive = 1'b1;
    nxt();
    release dut.crd_arrive;
    spur = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("err_sticky", error, 1);
      check("err_credit_sat", credit_cnt, 6);
      nxt();
    end
    s_rst = 1;
    nxt();
    s_rst = 0;
    @(negedge clk);
    check("err_cleared", error, 0);
    nxt();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
